sync_fifo: RTL

Single-clock, parametrised-depth FIFO with valid/ready handshakes on both sides. Generalises the 1-deep/2-register CDC FIFO to DEPTH entries in one clock domain. Adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush and a sticky overflow-attempt flag. Used as the general elastic buffer between pipeline stages.

---
 rtl/sync_fifo.sv | 100 ++++++++++
 1 files changed

// File: rtl/sync_fifo.sv
// Single-clock FWFT FIFO with valid/ready handshakes, occupancy count,
// almost-full/almost-empty flags, synchronous flush and sticky overflow.
module sync_fifo #(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 8,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_valid,
  output logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  generate
    if ((WIDTH < 1) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two >= 2 and WIDTH >= 1");
    end
    if ((AFULL_LEVEL < 0) || (AFULL_LEVEL > DEPTH)) begin : g_bad_afull
      $error("sync_fifo: AFULL_LEVEL must lie in 0..DEPTH");
    end
  endgenerate

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;
  logic             wr_ready_s;
  logic             rd_ready_s;
  logic             wr_fire_s;
  logic             rd_fire_s;

  // Full/empty come from the count so pointer equality is never ambiguous.
  assign wr_ready_s = (count_r != CNT_MAX);
  assign rd_ready_s = (count_r != {CW{1'b0}});
  assign wr_fire_s  = wr_valid & wr_ready_s & ~flush;
  assign rd_fire_s  = rd_valid & rd_ready_s & ~flush;

  // Pointer, occupancy and sticky overflow state; flush outranks any transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_fire_s, rd_fire_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (wr_valid && !wr_ready_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Storage is left unreset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign wr_ready     = wr_ready_s;
  assign rd_ready     = rd_ready_s;
  assign rd_data      = mem_r[rd_ptr_r];
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign almost_full  = (int'(count_r) >= AFULL_LEVEL);
  assign almost_empty = (int'(count_r) <= AEMPTY_LEVEL);

endmodule
